matmul_ctrl: RTL

MATMUL_CTRL -- requirements
Module: matmul_ctrl

---
 rtl/matmul_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequencer for one 3x3 matrix multiply.
// Loads 9 weight words and 9 input words into the memory bank, waits for the
// bank's start flag, runs three MAC steps (one per row), drains the MAC
// pipeline for two cycles, and then pulses done. An abort from any busy state
// clears the bank and the accumulators.
// Optional build macro MATMUL_CTRL_START_TIMEOUT_EN adds a 16-cycle start
// timeout in WAITS. The timeout sets the sticky err flag and aborts.
module matmul_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       abort,
  input  logic       valid_in,
  input  logic       start,
  output logic       ldw,
  output logic       ldx,
  output logic       clear_mem,
  output logic       clear_mac,
  output logic       unload1,
  output logic       unload2,
  output logic       unload3,
  output logic       ld,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] word_cnt
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CLR   = 4'd1,
    S_LOADW = 4'd2,
    S_LOADX = 4'd3,
    S_WAITS = 4'd4,
    S_MAC   = 4'd5,
    S_DRAIN = 4'd6,
    S_DONE  = 4'd7,
    S_ABT   = 4'd8
  } state_t;

  state_t     state_r, state_next_s;
  logic [3:0] word_cnt_r, word_cnt_next_s;
  logic [1:0] step_r, step_next_s;
  logic       drain_r, drain_next_s;
`ifdef MATMUL_CTRL_START_TIMEOUT_EN
  logic [3:0] tmo_r, tmo_next_s;
  logic       err_r, err_next_s;
`endif

  // State and counter registers; reset drops straight back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      word_cnt_r <= 4'd0;
      step_r     <= 2'd0;
      drain_r    <= 1'b0;
`ifdef MATMUL_CTRL_START_TIMEOUT_EN
      tmo_r      <= 4'd0;
      err_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_next_s;
      word_cnt_r <= word_cnt_next_s;
      step_r     <= step_next_s;
      drain_r    <= drain_next_s;
`ifdef MATMUL_CTRL_START_TIMEOUT_EN
      tmo_r      <= tmo_next_s;
      err_r      <= err_next_s;
`endif
    end
  end

  // Next-state and counter logic; abort overrides every other transition
  always_comb begin
    state_next_s    = state_r;
    word_cnt_next_s = word_cnt_r;
    step_next_s     = step_r;
    drain_next_s    = drain_r;
`ifdef MATMUL_CTRL_START_TIMEOUT_EN
    tmo_next_s      = tmo_r;
    err_next_s      = err_r;
`endif
    if ((state_r != S_IDLE) && abort) begin
      state_next_s    = S_ABT;
      word_cnt_next_s = 4'd0;
      step_next_s     = 2'd0;
      drain_next_s    = 1'b0;
`ifdef MATMUL_CTRL_START_TIMEOUT_EN
      tmo_next_s      = 4'd0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (go) begin
            state_next_s = S_CLR;
`ifdef MATMUL_CTRL_START_TIMEOUT_EN
            err_next_s   = 1'b0;
`endif
          end else begin
            state_next_s = S_IDLE;
          end
        end
        S_CLR: begin
          word_cnt_next_s = 4'd0;
          state_next_s    = S_LOADW;
        end
        S_LOADW, S_LOADX: begin
          if (valid_in) begin
            if (word_cnt_r == 4'd8) begin
              word_cnt_next_s = 4'd0;
              state_next_s    = (state_r == S_LOADW) ? S_LOADX : S_WAITS;
            end else begin
              word_cnt_next_s = word_cnt_r + 4'd1;
            end
          end else begin
            word_cnt_next_s = word_cnt_r;
          end
        end
        S_WAITS: begin
          if (start) begin
            state_next_s = S_MAC;
            step_next_s  = 2'd0;
`ifdef MATMUL_CTRL_START_TIMEOUT_EN
            tmo_next_s   = 4'd0;
          end else if (tmo_r == 4'd15) begin
            // Sixteenth idle WAITS cycle: give up and flag the timeout
            tmo_next_s   = 4'd0;
            err_next_s   = 1'b1;
            state_next_s = S_ABT;
          end else begin
            tmo_next_s   = tmo_r + 4'd1;
`else
          end else begin
            state_next_s = S_WAITS;
`endif
          end
        end
        S_MAC: begin
          if (step_r == 2'd2) begin
            step_next_s  = 2'd0;
            drain_next_s = 1'b0;
            state_next_s = S_DRAIN;
          end else begin
            step_next_s  = step_r + 2'd1;
          end
        end
        S_DRAIN: begin
          if (drain_r) begin
            drain_next_s = 1'b0;
            state_next_s = S_DONE;
          end else begin
            drain_next_s = 1'b1;
          end
        end
        S_DONE:  state_next_s = S_IDLE;
        S_ABT: begin
          word_cnt_next_s = 4'd0;
          state_next_s    = S_IDLE;
        end
        default: state_next_s = S_IDLE;
      endcase
    end
  end

  // Output decode: everything except ldw/ldx comes from registered state only
  always_comb begin
    ldw       = 1'b0;
    ldx       = 1'b0;
    clear_mem = 1'b0;
    clear_mac = 1'b0;
    unload1   = 1'b0;
    unload2   = 1'b0;
    unload3   = 1'b0;
    ld        = 1'b0;
    done      = 1'b0;
    case (state_r)
      S_CLR, S_ABT: begin
        clear_mem = 1'b1;
        clear_mac = 1'b1;
      end
      S_LOADW: ldw = valid_in;
      S_LOADX: ldx = valid_in;
      S_MAC: begin
        ld = 1'b1;
        case (step_r)
          2'd0:    unload1 = 1'b1;
          2'd1:    unload2 = 1'b1;
          2'd2:    unload3 = 1'b1;
          default: unload1 = 1'b0;
        endcase
      end
      S_DONE:  done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  assign busy     = (state_r != S_IDLE);
  assign word_cnt = word_cnt_r;
`ifdef MATMUL_CTRL_START_TIMEOUT_EN
  assign err      = err_r;
`else
  assign err      = 1'b0;
`endif

endmodule
